// File: rtl/alu_bitserial_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_bitserial_seq: bit-serial ALU sequencer, LSB first, start/valid.     |
// | Optional ALU_SLTU_EN adds unsigned set-less-than on alu_ctrl 1000. r1.0  |
// +--------------------------------------------------------------------------+
module alu_bitserial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             valid
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_NOR  = 4'b1100;
  localparam logic [3:0] C_SLTU = 4'b1000;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_sh_q, result_q;
  logic [3:0]       ctrl_q;
  logic             ainv_q, binv_q;
  logic [1:0]       op_q;
  logic [CW-1:0]    count_q;
  logic             carry_q, cin_msb_q, cout_msb_q, set_msb_q;
  logic             zero_q, ovf_q, valid_q;

  logic             dec_ainv_d, dec_binv_d;
  logic [1:0]       dec_op_d;
  logic             abit_d, bbit_d, sum_d, cout_d, slice_d;
  logic             ovf_d, fin_ovf_d;
  logic [WIDTH-1:0] fin_res_d;

  always_comb begin
    dec_ainv_d = 1'b0;
    dec_binv_d = 1'b0;
    dec_op_d   = 2'b00;
    case (alu_ctrl)
      C_OR:  dec_op_d = 2'b01;
      C_ADD: dec_op_d = 2'b10;
      C_SUB: begin dec_binv_d = 1'b1; dec_op_d = 2'b10; end
      C_SLT: begin dec_binv_d = 1'b1; dec_op_d = 2'b11; end
      C_NOR: begin dec_ainv_d = 1'b1; dec_binv_d = 1'b1; end
`ifdef ALU_SLTU_EN
      C_SLTU: begin dec_binv_d = 1'b1; dec_op_d = 2'b11; end
`endif
      default: dec_op_d = 2'b00;
    endcase
  end

  // One-bit ALU slice; Less is tied to 0 here and fixed up in FINISH.
  always_comb begin
    abit_d = a_q[count_q] ^ ainv_q;
    bbit_d = b_q[count_q] ^ binv_q;
    sum_d  = abit_d ^ bbit_d ^ carry_q;
    cout_d = (abit_d & bbit_d) | (abit_d & carry_q) | (bbit_d & carry_q);
    case (op_q)
      2'b00:   slice_d = abit_d & bbit_d;
      2'b01:   slice_d = abit_d | bbit_d;
      2'b10:   slice_d = sum_d;
      default: slice_d = 1'b0;
    endcase
  end

  always_comb begin
    ovf_d     = cin_msb_q ^ cout_msb_q;
    fin_res_d = '0;
    fin_ovf_d = 1'b0;
    case (ctrl_q)
      C_AND, C_OR, C_NOR: fin_res_d = res_sh_q;
      C_ADD, C_SUB: begin
        fin_res_d = res_sh_q;
        fin_ovf_d = ovf_d;
      end
      C_SLT: fin_res_d = {{(WIDTH-1){1'b0}}, set_msb_q ^ ovf_d};
`ifdef ALU_SLTU_EN
      C_SLTU: fin_res_d = {{(WIDTH-1){1'b0}}, ~cout_msb_q};
`endif
      default: fin_res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_SHIFT;
      S_SHIFT:  if (count_q == LAST) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      ainv_q     <= 1'b0;
      binv_q     <= 1'b0;
      op_q       <= '0;
      count_q    <= '0;
      carry_q    <= 1'b0;
      res_sh_q   <= '0;
      cin_msb_q  <= 1'b0;
      cout_msb_q <= 1'b0;
      set_msb_q  <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          a_q     <= a;
          b_q     <= b;
          ctrl_q  <= alu_ctrl;
          ainv_q  <= dec_ainv_d;
          binv_q  <= dec_binv_d;
          op_q    <= dec_op_d;
          carry_q <= dec_binv_d;
          count_q <= '0;
        end
        S_SHIFT: begin
          carry_q  <= cout_d;
          res_sh_q <= {slice_d, res_sh_q[WIDTH-1:1]};
          count_q  <= count_q + CW'(1);
          if (count_q == LAST) begin
            cin_msb_q  <= carry_q;
            cout_msb_q <= cout_d;
            set_msb_q  <= sum_d;
          end
        end
        S_FINISH: begin
          result_q <= fin_res_d;
          zero_q   <= (fin_res_d == '0);
          ovf_q    <= fin_ovf_d;
          valid_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign valid    = valid_q;

endmodule
`default_nettype wire
